bcd_clock_core: RTL and testbench



---
 rtl/clock_pkg.sv | 59 +++++
 rtl/bcd_clock_core_seg7_decode.sv | 13 +
 rtl/bcd_clock_core.sv | 179 +++++++++++++++++
 tb/tb_bcd_clock_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, field limits and seven-segment glyphs for the BCD clock.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_field_t;

    localparam bcd_field_t CC_MAX   = 8'h99;
    localparam bcd_field_t SS_MAX   = 8'h59;
    localparam bcd_field_t MM_MAX   = 8'h59;
    localparam bcd_field_t HH24_MAX = 8'h23;
    localparam bcd_field_t HH12_MAX = 8'h12;
    localparam bcd_field_t HH12_MIN = 8'h01;

    // Glyphs are {g..a}, segment lit = 1
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_drive(bcd_digit_t d, bit active_low);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = 7'h00;
        endcase
        return active_low ? ~g : g;
    endfunction

    // Valid BCD compares correctly as plain binary
    function automatic logic bcd_valid(bcd_field_t f, bcd_field_t lo,
                                       bcd_field_t hi);
        return (f[7:4] <= 4'd9) && (f[3:0] <= 4'd9) && (f >= lo) && (f <= hi);
    endfunction

    function automatic bcd_field_t bcd_inc(bcd_field_t f, bcd_field_t max);
        if (f == max)
            return 8'h00;
        else if (f[3:0] == 4'd9)
            return {f[7:4] + 4'd1, 4'd0};
        else
            return {f[7:4], f[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_clock_core_seg7_decode.sv
// Combinational BCD digit to seven-segment {g..a} decoder.
module seg7_decode
    import clock_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    assign seg = seg_drive(digit, ACTIVE_LOW);

endmodule

// File: rtl/bcd_clock_core.sv
// BCD time-of-day engine with field loads and registered HEX outputs.
// Optional alarm compare/latch enabled by defining CLOCK_ALARM_EN.
module bcd_clock_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 100,
    parameter int MODE_12H       = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [7:0]  time_in,
    input  logic        set_hour,
    input  logic        set_minute,
    input  logic        set_second,
    input  logic        set_mil,
    output logic [31:0] time_bcd,
    output logic        pm,
    output logic        tick_sec,
    output logic        set_err,
`ifdef CLOCK_ALARM_EN
    input  logic        alarm_set,
    input  logic        alarm_clr,
    output logic        alarm_hit,
`endif
    output logic [6:0]  hex7,
    output logic [6:0]  hex6,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

    localparam bit         IS_12H = (MODE_12H != 0);
    localparam bit         SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam bcd_field_t HH_MIN = IS_12H ? HH12_MIN : 8'h00;
    localparam bcd_field_t HH_MAX = IS_12H ? HH12_MAX : HH24_MAX;
    localparam bcd_field_t HH_RST = IS_12H ? HH12_MAX : 8'h00;
    localparam logic [31:0] RST_TIME = {HH_RST, 24'h000000};

    logic [PW-1:0] presc, presc_n;
    bcd_field_t    hh, mm, ss, cc;
    bcd_field_t    hh_n, mm_n, ss_n, cc_n;
    logic          pm_n;
    logic          tick;
    logic          ld_hh, ld_mm, ld_ss, ld_cc, bad;
    logic          inc_cc, inc_ss, inc_mm, inc_hh;
    logic [6:0]    seg_d [8];
    logic [6:0]    hex_q [8];

    assign time_bcd = {hh, mm, ss, cc};
    assign tick     = run && (presc == PRESC_TOP);

    assign ld_hh = set_hour   && bcd_valid(time_in, HH_MIN, HH_MAX);
    assign ld_mm = set_minute && bcd_valid(time_in, 8'h00, MM_MAX);
    assign ld_ss = set_second && bcd_valid(time_in, 8'h00, SS_MAX);
    assign ld_cc = set_mil    && bcd_valid(time_in, 8'h00, CC_MAX);
    assign bad   = (set_hour && !ld_hh) || (set_minute && !ld_mm) ||
                   (set_second && !ld_ss) || (set_mil && !ld_cc);

    // A loaded field neither takes a carry in nor passes one on
    assign inc_cc = tick && !ld_cc && !ld_ss;
    assign inc_ss = inc_cc && (cc == CC_MAX);
    assign inc_mm = inc_ss && (ss == SS_MAX) && !ld_mm;
    assign inc_hh = inc_mm && (mm == MM_MAX) && !ld_hh;

    always_comb begin
        presc_n = presc;
        cc_n    = cc;
        ss_n    = ss;
        mm_n    = mm;
        hh_n    = hh;
        pm_n    = pm;
        if (ld_ss)
            presc_n = '0;
        else if (tick)
            presc_n = '0;
        else if (run)
            presc_n = presc + PW'(1);
        if (inc_cc) cc_n = bcd_inc(cc, CC_MAX);
        if (ld_ss)  cc_n = 8'h00;
        if (ld_cc)  cc_n = time_in;
        if (inc_ss) ss_n = bcd_inc(ss, SS_MAX);
        if (ld_ss)  ss_n = time_in;
        if (inc_mm) mm_n = bcd_inc(mm, MM_MAX);
        if (ld_mm)  mm_n = time_in;
        if (inc_hh) begin
            if (IS_12H) begin
                hh_n = (hh == HH12_MAX) ? HH12_MIN : bcd_inc(hh, HH12_MAX);
                if (hh == 8'h11) pm_n = !pm;
            end else begin
                hh_n = bcd_inc(hh, HH24_MAX);
            end
        end
        if (ld_hh) hh_n = time_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            hh       <= HH_RST;
            mm       <= 8'h00;
            ss       <= 8'h00;
            cc       <= 8'h00;
            pm       <= 1'b0;
            tick_sec <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            presc    <= presc_n;
            hh       <= hh_n;
            mm       <= mm_n;
            ss       <= ss_n;
            cc       <= cc_n;
            pm       <= pm_n;
            tick_sec <= inc_ss;
            set_err  <= bad;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_seg
        seg7_decode #(
            .ACTIVE_LOW (SEG_AL)
        ) u_seg (
            .digit (time_bcd[4*i +: 4]),
            .seg   (seg_d[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                hex_q[i] <= seg_drive(RST_TIME[4*i +: 4], SEG_AL);
        end else begin
            for (int i = 0; i < 8; i++)
                hex_q[i] <= seg_d[i];
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

`ifdef CLOCK_ALARM_EN
    logic [15:0] alarm_q;
    logic        armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q   <= 16'h0000;
            armed     <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (alarm_set) begin
                alarm_q <= {hh, mm};
                armed   <= 1'b1;
            end
            if (alarm_clr)
                alarm_hit <= 1'b0;
            else if (armed && ({hh, mm} == alarm_q) &&
                     (ss == 8'h00) && (cc == 8'h00))
                alarm_hit <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_clock_core.sv
// Directed bench: 24-hour and 12-hour instances, 10 clocks per hundredth.
module tb_bcd_clock_core;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        run_a, sh_a, sm_a, ss_a, sc_a;
    logic [7:0]  tin_a;
    logic [31:0] time_a;
    logic        pm_a, tsec_a, err_a;
    logic [6:0]  ha7, ha6, ha5, ha4, ha3, ha2, ha1, ha0;

    logic        run_b, sh_b, sm_b, ss_b, sc_b;
    logic [7:0]  tin_b;
    logic [31:0] time_b;
    logic        pm_b, tsec_b, err_b;
    logic [6:0]  hb7, hb6, hb5, hb4, hb3, hb2, hb1, hb0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_clock_core #(
        .CLK_HZ (1000), .TICK_HZ (100), .MODE_12H (0), .SEG_ACTIVE_LOW (1)
    ) u24 (
        .clk (clk), .rst_n (rst_n), .run (run_a), .time_in (tin_a),
        .set_hour (sh_a), .set_minute (sm_a), .set_second (ss_a),
        .set_mil (sc_a), .time_bcd (time_a), .pm (pm_a),
        .tick_sec (tsec_a), .set_err (err_a),
        .hex7 (ha7), .hex6 (ha6), .hex5 (ha5), .hex4 (ha4),
        .hex3 (ha3), .hex2 (ha2), .hex1 (ha1), .hex0 (ha0)
    );

    bcd_clock_core #(
        .CLK_HZ (1000), .TICK_HZ (100), .MODE_12H (1), .SEG_ACTIVE_LOW (1)
    ) u12 (
        .clk (clk), .rst_n (rst_n), .run (run_b), .time_in (tin_b),
        .set_hour (sh_b), .set_minute (sm_b), .set_second (ss_b),
        .set_mil (sc_b), .time_bcd (time_b), .pm (pm_b),
        .tick_sec (tsec_b), .set_err (err_b),
        .hex7 (hb7), .hex6 (hb6), .hex5 (hb5), .hex4 (hb4),
        .hex3 (hb3), .hex2 (hb2), .hex1 (hb1), .hex0 (hb0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // f: 0 hour, 1 minute, 2 second, 3 hundredths
    task automatic ld_a(input int f, input logic [7:0] v);
        tin_a = v;
        sh_a = (f == 0); sm_a = (f == 1); ss_a = (f == 2); sc_a = (f == 3);
        cyc(1);
        sh_a = 0; sm_a = 0; ss_a = 0; sc_a = 0;
    endtask

    task automatic ld_b(input int f, input logic [7:0] v);
        tin_b = v;
        sh_b = (f == 0); sm_b = (f == 1); ss_b = (f == 2); sc_b = (f == 3);
        cyc(1);
        sh_b = 0; sm_b = 0; ss_b = 0; sc_b = 0;
    endtask

    initial begin
        rst_n = 0;
        run_a = 0; tin_a = 0; sh_a = 0; sm_a = 0; ss_a = 0; sc_a = 0;
        run_b = 0; tin_b = 0; sh_b = 0; sm_b = 0; ss_b = 0; sc_b = 0;
        cyc(2);

        chk("rst_time24", time_a, 32'h00000000);
        chk("rst_pm24", {31'd0, pm_a}, 0);
        chk("rst_tsec", {31'd0, tsec_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
        chk("rst_hex0", {25'd0, ha0}, 32'h40);
        chk("rst_hex7", {25'd0, ha7}, 32'h40);
        chk("rst_time12", time_b, 32'h12000000);
        chk("rst_pm12", {31'd0, pm_b}, 0);
        chk("rst_hex7_12", {25'd0, hb7}, 32'h79);
        chk("rst_hex6_12", {25'd0, hb6}, 32'h24);

        rst_n = 1;
        run_a = 1;
        cyc(9);
        chk("pre_tick", time_a, 32'h00000000);
        cyc(1);
        chk("first_tick", time_a, 32'h00000001);
        chk("hex0_lag", {25'd0, ha0}, 32'h40);
        cyc(1);
        chk("hex0_one", {25'd0, ha0}, 32'h79);
        run_a = 0;

        ld_a(0, 8'h23); ld_a(1, 8'h59); ld_a(2, 8'h59); ld_a(3, 8'h99);
        chk("load_2359", time_a, 32'h23595999);
        chk("load_noerr", {31'd0, err_a}, 0);
        run_a = 1;
        cyc(9);
        chk("wrap_hold", time_a, 32'h23595999);
        chk("wrap_tsec0", {31'd0, tsec_a}, 0);
        cyc(1);
        chk("day_wrap", time_a, 32'h00000000);
        chk("wrap_tsec1", {31'd0, tsec_a}, 1);
        cyc(1);
        chk("tsec_once", {31'd0, tsec_a}, 0);
        run_a = 0;

        ld_a(1, 8'h6A);
        chk("err_6A", {31'd0, err_a}, 1);
        chk("keep_6A", time_a, 32'h00000000);
        cyc(1);
        chk("err_clear", {31'd0, err_a}, 0);
        ld_a(1, 8'h60);
        chk("err_60", {31'd0, err_a}, 1);
        chk("keep_60", time_a, 32'h00000000);
        ld_a(1, 8'h45);
        chk("ok_45_err", {31'd0, err_a}, 0);
        chk("ok_45", time_a, 32'h00450000);

        tin_a = 8'h30; sh_a = 1; sm_a = 1;
        cyc(1);
        sh_a = 0; sm_a = 0;
        chk("dual_err", {31'd0, err_a}, 1);
        chk("dual_time", time_a, 32'h00300000);

        ld_a(1, 8'h10); ld_a(2, 8'h59); ld_a(3, 8'h99);
        chk("pre_coll", time_a, 32'h00105999);
        run_a = 1;
        cyc(9);
        tin_a = 8'h30; sm_a = 1;
        cyc(1);
        sm_a = 0;
        chk("collision", time_a, 32'h00300000);
        chk("coll_tsec", {31'd0, tsec_a}, 1);
        run_a = 0;

        ld_a(0, 8'h05); ld_a(1, 8'h30); ld_a(2, 8'h12); ld_a(3, 8'h99);
        run_a = 1;
        cyc(3);
        chk("mid_count", time_a, 32'h05301299);
        #3;
        rst_n = 0;
        #1;
        chk("async_time", time_a, 32'h00000000);
        chk("async_hex0", {25'd0, ha0}, 32'h40);
        cyc(1);
        rst_n = 1;
        cyc(9);
        chk("resume_pre", time_a, 32'h00000000);
        cyc(1);
        chk("resume", time_a, 32'h00000001);
        run_a = 0;

        ld_b(0, 8'h11); ld_b(1, 8'h59); ld_b(2, 8'h59); ld_b(3, 8'h99);
        chk("load_1159", time_b, 32'h11595999);
        ld_b(0, 8'h00);
        chk("err_h00", {31'd0, err_b}, 1);
        ld_b(0, 8'h13);
        chk("err_h13", {31'd0, err_b}, 1);
        chk("keep_h", time_b, 32'h11595999);
        run_b = 1;
        cyc(10);
        chk("noon", time_b, 32'h12000000);
        chk("noon_pm", {31'd0, pm_b}, 1);
        chk("noon_tsec", {31'd0, tsec_b}, 1);
        run_b = 0;

        ld_b(0, 8'h12); ld_b(1, 8'h59); ld_b(2, 8'h59); ld_b(3, 8'h99);
        run_b = 1;
        cyc(10);
        chk("one_pm", time_b, 32'h01000000);
        chk("one_pm_flag", {31'd0, pm_b}, 1);
        run_b = 0;
        cyc(1);
        chk("hex7_one", {25'd0, hb7}, 32'h40);
        chk("hex6_one", {25'd0, hb6}, 32'h79);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
